// File: rtl/ps_switch_ctrl.sv
// ps_switch_ctrl: applies privilege / compressed-ISA / satp updates after the pipeline drains,
// with an optional TLB flush and a settle window. Define PS_FLUSH_FILTER_EN to flush only on satp mode/ASID change.
//
// state  | meaning
// IDLE   | ready for a request, fetch running
// DRAIN  | request held, waiting for the pipeline to empty
// FLUSH  | TLB flush requested for the new ASID, waiting for done
// COMMIT | output registers load the held request
// SETTLE | stall held while new state propagates to fetch/translate
module ps_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_priv,
  input  logic        i_req_isa_c,
  input  logic [31:0] i_req_satp,
  input  logic        i_req_satp_wr,
  input  logic        i_pipe_empty,
  output logic        o_tlb_flush_req,
  output logic [8:0]  o_tlb_flush_asid,
  input  logic        i_tlb_flush_done,
  output logic        o_stall_fetch,
  output logic        o_commit,
  output logic [1:0]  o_priv,
  output logic        o_isa_c,
  output logic [31:0] o_satp
);

  typedef logic [31:0] reg_data_t;
  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, COMMIT, SETTLE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] hold_priv;
  logic       hold_isa_c;
  reg_data_t  hold_satp;
  logic       hold_satp_wr;
  logic       accept;
  logic       flush_needed;

  assign o_req_ready = (state == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;

`ifdef PS_FLUSH_FILTER_EN
  // Compared against the pre-commit satp: only a mode or ASID change invalidates translations.
  assign flush_needed = hold_satp_wr &&
                        ((hold_satp[31] != o_satp[31]) || (hold_satp[30:22] != o_satp[30:22]));
`else
  assign flush_needed = hold_satp_wr;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (accept) state_nxt = DRAIN;
      DRAIN:  if (i_pipe_empty) state_nxt = flush_needed ? FLUSH : COMMIT;
      FLUSH:  if (i_tlb_flush_done) state_nxt = COMMIT;
      COMMIT: begin
        if (SETTLE_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_INIT;
        end
      end
      SETTLE: begin
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hold_priv    <= '0;
      hold_isa_c   <= 1'b0;
      hold_satp    <= '0;
      hold_satp_wr <= 1'b0;
      o_priv       <= 2'b11;
      o_isa_c      <= 1'b1;
      o_satp       <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_priv    <= i_req_priv;
        hold_isa_c   <= i_req_isa_c;
        hold_satp    <= i_req_satp;
        hold_satp_wr <= i_req_satp_wr;
      end
      if (state == COMMIT) begin
        o_priv  <= hold_priv;
        o_isa_c <= hold_isa_c;
        if (hold_satp_wr) o_satp <= hold_satp;
      end
    end
  end

  assign o_stall_fetch    = (state != IDLE);
  assign o_commit         = (state == COMMIT);
  assign o_tlb_flush_req  = (state == FLUSH);
  assign o_tlb_flush_asid = (state == FLUSH) ? hold_satp[30:22] : 9'd0;

endmodule
